// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle for mem_bus_arbiter.
//   D port : data load/store requester (d_req_i ... d_rdata_o)
//   I port : instruction fetch requester (i_req_i ... i_rdata_o)
//   flush_i, stallreq_o : pipeline control
//   bus_*  : single shared memory bus towards the slave
// modport master : arbiter side (drives grants, responses and the bus request)
// modport slave  : environment side (requesters, pipe control and memory slave)
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  d_req_i;
   logic                  d_we_i;
   logic [ADDR_WIDTH-1:0] d_addr_i;
   logic [DATA_WIDTH-1:0] d_wdata_i;
   logic [3:0]            d_be_i;
   logic                  d_gnt_o;
   logic                  d_rvalid_o;
   logic [DATA_WIDTH-1:0] d_rdata_o;

   logic                  i_req_i;
   logic [ADDR_WIDTH-1:0] i_addr_i;
   logic                  i_gnt_o;
   logic                  i_rvalid_o;
   logic [DATA_WIDTH-1:0] i_rdata_o;

   logic                  flush_i;
   logic                  stallreq_o;

   logic                  bus_req_o;
   logic                  bus_we_o;
   logic [ADDR_WIDTH-1:0] bus_addr_o;
   logic [DATA_WIDTH-1:0] bus_wdata_o;
   logic [3:0]            bus_be_o;
   logic                  bus_gnt_i;
   logic                  bus_rvalid_i;
   logic [DATA_WIDTH-1:0] bus_rdata_i;

   modport master (
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      output d_gnt_o, d_rvalid_o, d_rdata_o,
      input  i_req_i, i_addr_i,
      output i_gnt_o, i_rvalid_o, i_rdata_o,
      input  flush_i,
      output stallreq_o,
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
   );

   modport slave (
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      input  d_gnt_o, d_rvalid_o, d_rdata_o,
      output i_req_i, i_addr_i,
      input  i_gnt_o, i_rvalid_o, i_rdata_o,
      output flush_i,
      input  stallreq_o,
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
      output bus_gnt_i, bus_rvalid_i, bus_rdata_i
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with one outstanding transaction.
// Data port D has fixed priority over fetch port I; after IF_STARVE_MAX
// consecutive D grants taken while fetch was waiting, fetch is forced to win.
// Ports:
//   clk_i  : core clock, rising edge
//   rst_i  : asynchronous reset, active low
//   bus    : mem_bus_arbiter_if.master (requesters, flush/stall, shared bus)
// Grants, responses, rdata and stallreq are combinational; bus_* are registered.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned IF_STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   mem_bus_arbiter_if.master bus
);
   localparam int unsigned       CNT_W      = $clog2(IF_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(IF_STARVE_MAX);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;
   typedef enum logic {OWN_D, OWN_I} owner_t;

   state_t           state;
   owner_t           owner;
   logic             discard;
   logic [CNT_W-1:0] starve_cnt;

   logic rsp_now;
   logic arb_point;
   logic force_i;
   logic d_win;
   logic i_win;
   logic d_rv;
   logic i_rv;

   // Arbitration: back-to-back grant allowed in the response cycle.
   always_comb begin
      rsp_now   = (state == ST_RESP) && bus.bus_rvalid_i;
      arb_point = (state == ST_IDLE) || rsp_now;
      force_i   = bus.i_req_i && (starve_cnt == STARVE_LIM);
      d_win     = arb_point && bus.d_req_i && !force_i;
      i_win     = arb_point && bus.i_req_i && !d_win;
   end

   // Master-side outputs; held at zero while reset is asserted.
   always_comb begin
      d_rv            = rst_i && rsp_now && (owner == OWN_D);
      // A stale fetch (earlier flush or flush in this very cycle) is swallowed.
      i_rv            = rst_i && rsp_now && (owner == OWN_I) && !discard && !bus.flush_i;
      bus.d_gnt_o     = rst_i && d_win;
      bus.i_gnt_o     = rst_i && i_win;
      bus.d_rvalid_o  = d_rv;
      bus.i_rvalid_o  = i_rv;
      bus.d_rdata_o   = d_rv ? bus.bus_rdata_i : '0;
      bus.i_rdata_o   = i_rv ? bus.bus_rdata_i : '0;
      bus.stallreq_o  = rst_i && ((bus.d_req_i && !d_win) ||
                                  ((owner == OWN_D) && (state != ST_IDLE) && !rsp_now));
   end

   // Transaction state, owner tracking and registered bus request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state           <= ST_IDLE;
         owner           <= OWN_D;
         discard         <= 1'b0;
         starve_cnt      <= '0;
         bus.bus_req_o   <= 1'b0;
         bus.bus_we_o    <= 1'b0;
         bus.bus_addr_o  <= ADDR_WIDTH'(0);
         bus.bus_wdata_o <= DATA_WIDTH'(0);
         bus.bus_be_o    <= 4'h0;
      end else if (d_win) begin
         state           <= ST_ADDR;
         owner           <= OWN_D;
         discard         <= 1'b0;
         bus.bus_req_o   <= 1'b1;
         bus.bus_we_o    <= bus.d_we_i;
         bus.bus_addr_o  <= bus.d_addr_i;
         bus.bus_wdata_o <= bus.d_wdata_i;
         bus.bus_be_o    <= bus.d_be_i;
         // Count only wins that made a waiting fetch lose.
         if (bus.i_req_i && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end else if (i_win) begin
         state           <= ST_ADDR;
         owner           <= OWN_I;
         discard         <= 1'b0;
         starve_cnt      <= '0;
         bus.bus_req_o   <= 1'b1;
         bus.bus_we_o    <= 1'b0;
         bus.bus_addr_o  <= bus.i_addr_i;
         bus.bus_wdata_o <= DATA_WIDTH'(0);
         bus.bus_be_o    <= 4'hF;
      end else begin
         case (state)
            ST_ADDR: begin
               if (bus.bus_gnt_i) begin
                  state         <= ST_RESP;
                  bus.bus_req_o <= 1'b0;
               end
               if ((owner == OWN_I) && bus.flush_i) begin
                  discard <= 1'b1;
               end
            end
            ST_RESP: begin
               if (bus.bus_rvalid_i) begin
                  state <= ST_IDLE;
               end else if ((owner == OWN_I) && bus.flush_i) begin
                  discard <= 1'b1;
               end
            end
            default: begin
               state         <= ST_IDLE;
               bus.bus_req_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;
   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned STARVE = 4;
   localparam bit T = 1'b1;
   localparam bit F = 1'b0;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IF_STARVE_MAX(STARVE)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bif.master)
   );

   typedef struct {
      bit          d_req, d_we, i_req, flush, bgnt, brv;
      logic [31:0] addr, brdata;
      bit          e_dg, e_ig, e_dv, e_iv, e_st, st_care, e_br;
      logic [31:0] e_baddr, e_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bif.d_req_i = 1'b0; bif.d_we_i = 1'b0; bif.d_addr_i = '0; bif.d_wdata_i = '0;
      bif.d_be_i = 4'h0; bif.i_req_i = 1'b0; bif.i_addr_i = '0; bif.flush_i = 1'b0;
      bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_rdata_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " bus_req"},   32'(bif.bus_req_o), 32'h0);
      chk({tag, " bus_we"},    32'(bif.bus_we_o), 32'h0);
      chk({tag, " bus_addr"},  bif.bus_addr_o, 32'h0);
      chk({tag, " bus_wdata"}, bif.bus_wdata_o, 32'h0);
      chk({tag, " bus_be"},    32'(bif.bus_be_o), 32'h0);
      chk({tag, " d_gnt"},     32'(bif.d_gnt_o), 32'h0);
      chk({tag, " i_gnt"},     32'(bif.i_gnt_o), 32'h0);
      chk({tag, " d_rvalid"},  32'(bif.d_rvalid_o), 32'h0);
      chk({tag, " i_rvalid"},  32'(bif.i_rvalid_o), 32'h0);
      chk({tag, " d_rdata"},   bif.d_rdata_o, 32'h0);
      chk({tag, " i_rdata"},   bif.i_rdata_o, 32'h0);
      chk({tag, " stallreq"},  32'(bif.stallreq_o), 32'h0);
   endtask

   task automatic run_table();
      foreach (vecs[k]) begin
         bif.d_req_i = vecs[k].d_req; bif.d_we_i = vecs[k].d_we;
         bif.d_addr_i = vecs[k].addr; bif.d_wdata_i = '0; bif.d_be_i = 4'hF;
         bif.i_req_i = vecs[k].i_req; bif.i_addr_i = vecs[k].addr;
         bif.flush_i = vecs[k].flush; bif.bus_gnt_i = vecs[k].bgnt;
         bif.bus_rvalid_i = vecs[k].brv; bif.bus_rdata_i = vecs[k].brdata;
         #4;
         chk($sformatf("vec%0d d_gnt", k), 32'(bif.d_gnt_o), 32'(vecs[k].e_dg));
         chk($sformatf("vec%0d i_gnt", k), 32'(bif.i_gnt_o), 32'(vecs[k].e_ig));
         chk($sformatf("vec%0d d_rvalid", k), 32'(bif.d_rvalid_o), 32'(vecs[k].e_dv));
         chk($sformatf("vec%0d i_rvalid", k), 32'(bif.i_rvalid_o), 32'(vecs[k].e_iv));
         chk($sformatf("vec%0d d_rdata", k), bif.d_rdata_o, vecs[k].e_dv ? vecs[k].e_rdata : 32'h0);
         chk($sformatf("vec%0d i_rdata", k), bif.i_rdata_o, vecs[k].e_iv ? vecs[k].e_rdata : 32'h0);
         chk($sformatf("vec%0d bus_req", k), 32'(bif.bus_req_o), 32'(vecs[k].e_br));
         if (vecs[k].st_care)
            chk($sformatf("vec%0d stallreq", k), 32'(bif.stallreq_o), 32'(vecs[k].e_st));
         if (vecs[k].e_br)
            chk($sformatf("vec%0d bus_addr", k), bif.bus_addr_o, vecs[k].e_baddr);
         tick();
      end
   endtask

   // Both requesters always asking, zero-wait slave: grant pattern and spacing.
   task automatic seq_starve();
      string order;
      int    last;
      bit    pend;
      order = "";
      last  = -1;
      pend  = 1'b0;
      do_reset();
      bif.d_req_i = 1'b1; bif.d_addr_i = 32'h4000; bif.d_be_i = 4'hF;
      bif.i_req_i = 1'b1; bif.i_addr_i = 32'h0100;
      for (int c = 0; c < 40 && order.len() < 10; c++) begin
         bif.bus_gnt_i    = bif.bus_req_o;
         bif.bus_rvalid_i = pend;
         #4;
         if (bif.d_gnt_o || bif.i_gnt_o) begin
            if (last >= 0) chk("starve spacing", 32'(c - last), 32'd2);
            chk("starve single gnt", 32'(bif.d_gnt_o & bif.i_gnt_o), 32'h0);
            last  = c;
            order = {order, bif.d_gnt_o ? "D" : "I"};
         end
         pend = bif.bus_gnt_i;
         tick();
      end
      checks++;
      if (order != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL starve order actual=%s required=DDDDIDDDDI", order);
      end
   endtask

   // Store held through a 5-cycle slave gnt stall, with a blocked second D request.
   task automatic seq_store_stall();
      do_reset();
      bif.d_req_i = 1'b1; bif.d_we_i = 1'b1; bif.d_addr_i = 32'h2004;
      bif.d_wdata_i = 32'h55; bif.d_be_i = 4'b0001;
      #4;
      chk("st d_gnt", 32'(bif.d_gnt_o), 32'h1);
      tick();
      bif.d_req_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 2) begin
            bif.d_req_i = 1'b1; bif.d_we_i = 1'b0; bif.d_addr_i = 32'h3000;
            bif.d_wdata_i = 32'h0; bif.d_be_i = 4'hF;
         end
         #4;
         chk($sformatf("st%0d bus_req", c), 32'(bif.bus_req_o), 32'h1);
         chk($sformatf("st%0d bus_we", c), 32'(bif.bus_we_o), 32'h1);
         chk($sformatf("st%0d bus_addr", c), bif.bus_addr_o, 32'h2004);
         chk($sformatf("st%0d bus_wdata", c), bif.bus_wdata_o, 32'h55);
         chk($sformatf("st%0d bus_be", c), 32'(bif.bus_be_o), 32'h1);
         chk($sformatf("st%0d stallreq", c), 32'(bif.stallreq_o), 32'h1);
         if (c >= 2) chk($sformatf("st%0d d_gnt", c), 32'(bif.d_gnt_o), 32'h0);
         tick();
      end
      bif.bus_gnt_i = 1'b1;
      #4;
      chk("st gnt bus_req", 32'(bif.bus_req_o), 32'h1);
      tick();
      bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h0;
      #4;
      chk("st ack d_rvalid", 32'(bif.d_rvalid_o), 32'h1);
      chk("st ack d_rdata", bif.d_rdata_o, 32'h0);
      chk("st ack d_gnt", 32'(bif.d_gnt_o), 32'h1);
      chk("st ack stallreq", 32'(bif.stallreq_o), 32'h0);
      tick();
      bif.bus_rvalid_i = 1'b0; bif.d_req_i = 1'b0;
      #4;
      chk("st next bus_req", 32'(bif.bus_req_o), 32'h1);
      chk("st next bus_we", 32'(bif.bus_we_o), 32'h0);
      chk("st next bus_addr", bif.bus_addr_o, 32'h3000);
      tick();
   endtask

   // Reset asserted while a fetch waits for its response, then a clean fetch.
   task automatic seq_reset_resp();
      do_reset();
      bif.i_req_i = 1'b1; bif.i_addr_i = 32'h500;
      #4;
      chk("rr i_gnt", 32'(bif.i_gnt_o), 32'h1);
      tick();
      bif.i_req_i = 1'b0; bif.bus_gnt_i = 1'b1;
      #4;
      tick();
      bif.bus_gnt_i = 1'b0;
      #4;
      chk("rr resp bus_req", 32'(bif.bus_req_o), 32'h0);
      bif.d_req_i = 1'b1; bif.d_addr_i = 32'h9000; bif.d_be_i = 4'hF;
      bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'hCAFEF00D;
      #1;
      rst_i = 1'b0;
      #1;
      chk_all_zero("rr inrst");
      clear_inputs();
      tick();
      rst_i = 1'b1;
      bif.i_req_i = 1'b1; bif.i_addr_i = 32'h600;
      #4;
      chk("rr2 i_gnt", 32'(bif.i_gnt_o), 32'h1);
      tick();
      bif.i_req_i = 1'b0; bif.bus_gnt_i = 1'b1;
      #4;
      chk("rr2 bus_req", 32'(bif.bus_req_o), 32'h1);
      chk("rr2 bus_addr", bif.bus_addr_o, 32'h600);
      chk("rr2 bus_be", 32'(bif.bus_be_o), 32'hF);
      tick();
      bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h12345678;
      #4;
      chk("rr2 i_rvalid", 32'(bif.i_rvalid_o), 32'h1);
      chk("rr2 i_rdata", bif.i_rdata_o, 32'h12345678);
      tick();
      bif.bus_rvalid_i = 1'b0;
   endtask

   // Random traffic against a transaction-level model of the arbitration rules.
   task automatic seq_random(input int ncyc);
      bit          busy, accepted, own_d, stale;
      int          run, gwait, rwait;
      logic        m_we;
      logic [31:0] m_addr, m_wdata;
      logic [3:0]  m_be;
      bit          dp, ip, fl, bg, rv, arb, e_dg, e_ig, e_dv, e_iv, e_st, e_br;
      logic        dwe;
      logic [31:0] dad, dwd, iad, rd;
      logic [3:0]  dbe;
      busy = 0; accepted = 0; own_d = 1; stale = 0; run = 0; gwait = 0; rwait = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      dp = 0; ip = 0; dwe = 0; dad = 0; dwd = 0; iad = 0; dbe = 0;
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
         bg = busy && !accepted && (gwait == 0);
         rv = busy && accepted && (rwait == 0);
         rd = $urandom;
         if (!dp && ($urandom_range(0, 1) == 1)) begin
            dp = 1; dwe = 1'($urandom_range(0, 1)); dad = $urandom; dwd = $urandom;
            dbe = 4'($urandom_range(0, 15));
         end
         if (!ip && ($urandom_range(0, 2) != 0)) begin
            ip = 1; iad = $urandom;
         end
         fl = ($urandom_range(0, 7) == 0);
         bif.d_req_i = dp; bif.d_we_i = dwe; bif.d_addr_i = dad; bif.d_wdata_i = dwd;
         bif.d_be_i = dbe; bif.i_req_i = ip; bif.i_addr_i = iad; bif.flush_i = fl;
         bif.bus_gnt_i = bg; bif.bus_rvalid_i = rv; bif.bus_rdata_i = rd;
         #4;
         arb  = !busy || rv;
         e_dg = arb && dp && !(ip && (run == STARVE));
         e_ig = arb && ip && !e_dg;
         e_dv = rv && own_d;
         e_iv = rv && !own_d && !stale && !fl;
         e_st = (dp && !e_dg) || (busy && own_d && !rv);
         e_br = busy && !accepted;
         chk("rnd d_gnt", 32'(bif.d_gnt_o), 32'(e_dg));
         chk("rnd i_gnt", 32'(bif.i_gnt_o), 32'(e_ig));
         chk("rnd d_rvalid", 32'(bif.d_rvalid_o), 32'(e_dv));
         chk("rnd i_rvalid", 32'(bif.i_rvalid_o), 32'(e_iv));
         chk("rnd d_rdata", bif.d_rdata_o, e_dv ? rd : 32'h0);
         chk("rnd i_rdata", bif.i_rdata_o, e_iv ? rd : 32'h0);
         chk("rnd stallreq", 32'(bif.stallreq_o), 32'(e_st));
         chk("rnd bus_req", 32'(bif.bus_req_o), 32'(e_br));
         if (e_br) begin
            chk("rnd bus_we", 32'(bif.bus_we_o), 32'(m_we));
            chk("rnd bus_addr", bif.bus_addr_o, m_addr);
            chk("rnd bus_be", 32'(bif.bus_be_o), 32'(m_be));
            if (own_d) chk("rnd bus_wdata", bif.bus_wdata_o, m_wdata);
         end
         tick();
         if (e_dg || e_ig) begin
            busy = 1; accepted = 0; own_d = e_dg; stale = 0;
            gwait = $urandom_range(0, 3);
            if (e_dg) begin
               m_we = dwe; m_addr = dad; m_wdata = dwd; m_be = dbe; dp = 0;
               if (ip && run < STARVE) run++;
            end else begin
               m_we = 0; m_addr = iad; m_be = 4'hF; ip = 0; run = 0;
            end
         end else if (arb) begin
            busy = 0;
         end else begin
            if (!own_d && fl) stale = 1;
            if (bg) begin
               accepted = 1; rwait = $urandom_range(0, 3);
            end else if (e_br) begin
               gwait--;
            end else begin
               rwait--;
            end
         end
      end
   endtask

   initial begin
      clear_inputs();
      #1;
      rst_i = 1'b0;
      bif.d_req_i = 1'b1; bif.i_req_i = 1'b1; bif.bus_rvalid_i = 1'b1;
      bif.bus_rdata_i = 32'hFFFFFFFF;
      #2;
      chk_all_zero("reset");

      // D read of 0x1000: slave gnt at cycle 1, rvalid at cycle 3
      vecs.push_back(vec_t'{T,F,F,F,F,F, 32'h1000, 32'h0,      T,F,F,F,F,F,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,T,F, 32'h0,    32'h0,      F,F,F,F,T,T,T, 32'h1000, 32'h0});
      vecs.push_back(vec_t'{F,F,F,F,F,F, 32'h0,    32'h0,      F,F,F,F,T,T,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,F,T, 32'h0,    32'hDEADBEEF, F,F,T,F,F,T,F, 32'h0,  32'hDEADBEEF});
      vecs.push_back(vec_t'{F,F,F,F,F,F, 32'h0,    32'h0,      F,F,F,F,F,T,F, 32'h0,    32'h0});
      // fetch 0x200 flushed while waiting for its response
      vecs.push_back(vec_t'{F,F,T,F,F,F, 32'h200,  32'h0,      F,T,F,F,F,T,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,T,F, 32'h0,    32'h0,      F,F,F,F,F,T,T, 32'h200,  32'h0});
      vecs.push_back(vec_t'{F,F,F,T,F,F, 32'h0,    32'h0,      F,F,F,F,F,T,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,F,T, 32'h0,    32'h11111111, F,F,F,F,F,T,F, 32'h0,  32'h0});
      // fetch 0x300 returns normally
      vecs.push_back(vec_t'{F,F,T,F,F,F, 32'h300,  32'h0,      F,T,F,F,F,T,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,T,F, 32'h0,    32'h0,      F,F,F,F,F,T,T, 32'h300,  32'h0});
      vecs.push_back(vec_t'{F,F,F,F,F,T, 32'h0,    32'h22223333, F,F,F,T,F,T,F, 32'h0,  32'h22223333});
      // fetch 0x400 with flush in the rvalid cycle itself
      vecs.push_back(vec_t'{F,F,T,F,F,F, 32'h400,  32'h0,      F,T,F,F,F,T,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,F,T,F, 32'h0,    32'h0,      F,F,F,F,F,T,T, 32'h400,  32'h0});
      vecs.push_back(vec_t'{F,F,F,T,F,T, 32'h0,    32'h33334444, F,F,F,F,F,T,F, 32'h0,  32'h0});
      // flush during a D read has no effect
      vecs.push_back(vec_t'{T,F,F,T,F,F, 32'h700,  32'h0,      T,F,F,F,F,F,F, 32'h0,    32'h0});
      vecs.push_back(vec_t'{F,F,F,T,T,F, 32'h0,    32'h0,      F,F,F,F,T,T,T, 32'h700,  32'h0});
      vecs.push_back(vec_t'{F,F,F,T,F,T, 32'h0,    32'h5555AAAA, F,F,T,F,F,T,F, 32'h0,  32'h5555AAAA});
      vecs.push_back(vec_t'{F,F,F,F,F,F, 32'h0,    32'h0,      F,F,F,F,F,T,F, 32'h0,    32'h0});

      do_reset();
      run_table();
      seq_starve();
      seq_store_stall();
      seq_reset_resp();
      seq_random(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
